affine_to_jacob: RTL and testbench

Converts an affine elliptic-curve point (x, y) into Jacobian coordinates (X, Y, Z) = (x·z², y·z³, z) mod p, using a caller-supplied randomising factor z (point blinding). It is the entry-side counterpart of the Jacobian-to-affine x conversion: points enter the scalar-multiplication datapath through this block and leave through the back-conversion. The four modular products are computed with one shared bit-serial interleaved modular multiplier, one operand bit per clock.

---
 rtl/affine_to_jacob_if.sv | 33 +++
 rtl/affine_to_jacob.sv | 240 ++++++++++++++++++++++++
 tb/tb_affine_to_jacob.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/affine_to_jacob_if.sv
// ---------------------------------------------------------------------------
// affine_to_jacob_if
// Groups the request/result signals of the affine-to-Jacobian converter.
//   flag      : start request (master -> slave)
//   x, y, z, p: affine point, blinding factor and odd modulus (master -> slave)
//   x3,y3,z3  : Jacobian result X, Y, Z (slave -> master)
//   busy      : conversion in progress (slave -> master)
//   conv_done : one-cycle result-valid pulse (slave -> master)
// ---------------------------------------------------------------------------
interface affine_to_jacob_if #(
  parameter int WIDTH = 256
);
  logic             flag;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] x3;
  logic [WIDTH-1:0] y3;
  logic [WIDTH-1:0] z3;
  logic             busy;
  logic             conv_done;

  modport master (
    output flag, x, y, z, p,
    input  x3, y3, z3, busy, conv_done
  );

  modport slave (
    input  flag, x, y, z, p,
    output x3, y3, z3, busy, conv_done
  );
endinterface

// File: rtl/affine_to_jacob.sv
// ---------------------------------------------------------------------------
// affine_to_jacob
// Converts an affine point (x, y) into Jacobian (X, Y, Z) = (x*z^2, y*z^3, z)
// mod p using a caller-supplied blinding factor z. The four products are
// computed by a single shared bit-serial interleaved modular multiplier that
// consumes one bit of the multiplier operand per clock, MSB first.
//
// Ports:
//   clk  : clock, all state on the rising edge
//   nrst : asynchronous active-low reset
//   bus  : affine_to_jacob_if.slave (flag, x, y, z, p in; x3, y3, z3, busy,
//          conv_done out)
//
// Build option: BLINDING_EN
//   defined   : full blinded conversion, 4*WIDTH cycles flag-to-conv_done.
//   undefined : no multiplier; z and p are ignored, x3 <- x, y3 <- y,
//               z3 <- 1 and conv_done pulses the cycle after the request.
// ---------------------------------------------------------------------------
module affine_to_jacob #(
  parameter int WIDTH = 256
) (
  input  logic              clk,
  input  logic              nrst,
  affine_to_jacob_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL1 = 3'd1,
    ST_MUL2 = 3'd2,
    ST_MUL3 = 3'd3,
    ST_MUL4 = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_x3;
  logic [WIDTH-1:0] r_y3;
  logic [WIDTH-1:0] r_z3;
  logic             r_busy;
  logic             r_done;

  assign bus.x3        = r_x3;
  assign bus.y3        = r_y3;
  assign bus.z3        = r_z3;
  assign bus.busy      = r_busy;
  assign bus.conv_done = r_done;

`ifdef BLINDING_EN

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH+1:0] r_acc;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_z;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_z2;   // z^2 mod p
  logic [WIDTH-1:0] r_xj;   // Jacobian X, held until the final product lands
  logic [WIDTH-1:0] r_zc;   // z^3 mod p

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_bit;
  logic [WIDTH+1:0] w_acc_next;

  // One interleaved multiply step: acc = (2*acc + bit*a) mod m. Two guard
  // bits keep 2*acc + a exact so both compares see the untruncated value.
  function automatic logic [WIDTH+1:0] mod_step(
    input logic [WIDTH+1:0] acc,
    input logic [WIDTH-1:0] a,
    input logic             b_bit,
    input logic [WIDTH-1:0] m
  );
    logic [WIDTH+1:0] t;
    logic [WIDTH+1:0] mm;
    mm = {2'b00, m};
    t  = acc << 1;
    if (t >= mm) begin
      t = t - mm;
    end else begin
      t = t;
    end
    if (b_bit) begin
      t = t + {2'b00, a};
    end else begin
      t = t;
    end
    if (t >= mm) begin
      t = t - mm;
    end else begin
      t = t;
    end
    return t;
  endfunction

  // Select multiplicand/multiplier pair for the product of the current phase.
  always_comb begin
    w_a = {WIDTH{1'b0}};
    w_b = {WIDTH{1'b0}};
    case (r_state)
      ST_MUL1: begin w_a = r_z;  w_b = r_z;  end
      ST_MUL2: begin w_a = r_x;  w_b = r_z2; end
      ST_MUL3: begin w_a = r_z2; w_b = r_z;  end
      ST_MUL4: begin w_a = r_y;  w_b = r_zc; end
      default: begin w_a = {WIDTH{1'b0}}; w_b = {WIDTH{1'b0}}; end
    endcase
  end

  assign w_bit      = w_b[r_cnt];
  assign w_acc_next = mod_step(r_acc, w_a, w_bit, r_p);

  // Conversion sequencer: latch operands, run four WIDTH-step products,
  // publish the result and pulse conv_done.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_acc   <= {(WIDTH+2){1'b0}};
      r_x     <= {WIDTH{1'b0}};
      r_y     <= {WIDTH{1'b0}};
      r_z     <= {WIDTH{1'b0}};
      r_p     <= {WIDTH{1'b0}};
      r_z2    <= {WIDTH{1'b0}};
      r_xj    <= {WIDTH{1'b0}};
      r_zc    <= {WIDTH{1'b0}};
      r_x3    <= {WIDTH{1'b0}};
      r_y3    <= {WIDTH{1'b0}};
      r_z3    <= {WIDTH{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.flag) begin
            r_x     <= bus.x;
            r_y     <= bus.y;
            r_z     <= bus.z;
            r_p     <= bus.p;
            r_cnt   <= CW'(WIDTH - 1);
            r_acc   <= {(WIDTH+2){1'b0}};
            r_busy  <= 1'b1;
            r_state <= ST_MUL1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_MUL1, ST_MUL2, ST_MUL3, ST_MUL4: begin
          if (r_cnt == {CW{1'b0}}) begin
            // Last bit of this product: store it and arm the next phase.
            r_cnt <= CW'(WIDTH - 1);
            r_acc <= {(WIDTH+2){1'b0}};
            case (r_state)
              ST_MUL1: begin
                r_z2    <= w_acc_next[WIDTH-1:0];
                r_state <= ST_MUL2;
              end
              ST_MUL2: begin
                r_xj    <= w_acc_next[WIDTH-1:0];
                r_state <= ST_MUL3;
              end
              ST_MUL3: begin
                r_zc    <= w_acc_next[WIDTH-1:0];
                r_state <= ST_MUL4;
              end
              default: begin
                r_x3    <= r_xj;
                r_y3    <= w_acc_next[WIDTH-1:0];
                r_z3    <= r_z;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
            endcase
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          // A request arriving here is dropped, not queued.
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`else

  // Blinding factor and modulus have no role in the pass-through build.
  logic w_unused;
  assign w_unused = &{1'b0, bus.z, bus.p};

  // Pass-through sequencer: copy the affine point with Z = 1 in one cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_x3    <= {WIDTH{1'b0}};
      r_y3    <= {WIDTH{1'b0}};
      r_z3    <= {WIDTH{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.flag) begin
            r_x3    <= bus.x;
            r_y3    <= bus.y;
            r_z3    <= {{(WIDTH-1){1'b0}}, 1'b1};
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_affine_to_jacob.sv
// ---------------------------------------------------------------------------
// tb_affine_to_jacob
// Directed self-checking bench for affine_to_jacob at WIDTH = 256. Expected
// values are hand-computed; the BLINDING_EN build selects the blinded
// results, otherwise the pass-through results (x, y, 1) are expected.
// ---------------------------------------------------------------------------
module tb_affine_to_jacob;

  localparam int WIDTH = 256;
`ifdef BLINDING_EN
  localparam bit BLIND = 1'b1;
`else
  localparam bit BLIND = 1'b0;
`endif
  localparam int LAT = BLIND ? 4 * WIDTH : 0;

  logic clk;
  logic nrst;
  int   n_tests;
  int   n_fail;

  logic [WIDTH-1:0] p25519;
  logic [WIDTH-1:0] pm1;

  affine_to_jacob_if #(.WIDTH(WIDTH)) bus ();

  affine_to_jacob #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] blind_v,
                                            input logic [WIDTH-1:0] plain_v);
    return BLIND ? blind_v : plain_v;
  endfunction

  // Drive one request; returns at the falling edge after the sampling edge.
  task automatic start_conv(input logic [WIDTH-1:0] xi, input logic [WIDTH-1:0] yi,
                            input logic [WIDTH-1:0] zi, input logic [WIDTH-1:0] pi);
    bus.x    = xi;
    bus.y    = yi;
    bus.z    = zi;
    bus.p    = pi;
    bus.flag = 1'b1;
    @(negedge clk);
    bus.flag = 1'b0;
  endtask

  // Wait (bounded) for conv_done; offset is cycles already spent since E0.
  task automatic wait_done(input string tag, input int offset);
    int cnt;
    cnt = 0;
    check_value({tag, "_busy_run"}, {255'd0, bus.busy}, {255'd0, BLIND});
    while (bus.conv_done !== 1'b1 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    check_value({tag, "_latency"}, WIDTH'(cnt + offset), WIDTH'(LAT));
    check_value({tag, "_busy_done"}, {255'd0, bus.busy}, {WIDTH{1'b0}});
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] ex,
                              input logic [WIDTH-1:0] ey, input logic [WIDTH-1:0] ez);
    check_value({tag, "_x3"}, bus.x3, ex);
    check_value({tag, "_y3"}, bus.y3, ey);
    check_value({tag, "_z3"}, bus.z3, ez);
  endtask

  task automatic check_pulse_end(input string tag);
    @(negedge clk);
    check_value({tag, "_done_low"}, {255'd0, bus.conv_done}, {WIDTH{1'b0}});
    check_value({tag, "_busy_low"}, {255'd0, bus.busy}, {WIDTH{1'b0}});
  endtask

  initial begin
    int pulses;
    n_tests  = 0;
    n_fail   = 0;
    p25519   = (256'd1 << 255) - 256'd19;
    pm1      = p25519 - 256'd1;
    nrst     = 1'b0;
    bus.flag = 1'b0;
    bus.x    = '0;
    bus.y    = '0;
    bus.z    = '0;
    bus.p    = '0;
    repeat (3) @(negedge clk);
    check_result("rst", 256'd0, 256'd0, 256'd0);
    check_value("rst_busy", {255'd0, bus.busy}, 256'd0);
    check_value("rst_done", {255'd0, bus.conv_done}, 256'd0);
    nrst = 1'b1;
    @(negedge clk);

    // Basic vector: 9*9 = 23, 5*27 = 19 (mod 29).
    start_conv(256'd9, 256'd5, 256'd3, 256'd29);
    wait_done("t1", 0);
    check_result("t1", pick(256'd23, 256'd9), pick(256'd19, 256'd5), pick(256'd3, 256'd1));
    check_pulse_end("t1");

    // z = 1 and inputs at p-1.
    start_conv(256'd28, 256'd28, 256'd1, 256'd29);
    wait_done("t2", 0);
    check_result("t2", 256'd28, 256'd28, 256'd1);
    check_pulse_end("t2");

    // Full-width modulus with all operands at p-1: X = -1, Y = +1.
    start_conv(pm1, pm1, pm1, p25519);
    wait_done("t3", 0);
    check_result("t3", pm1, pick(256'd1, pm1), pick(pm1, 256'd1));
    check_pulse_end("t3");

    // Request during a conversion is ignored; inputs may change after E0.
    start_conv(256'd9, 256'd5, 256'd3, 256'd29);
`ifdef BLINDING_EN
    repeat (299) @(negedge clk);
    check_result("t4_hold", pm1, 256'd1, pm1);
    bus.x    = 256'd1;
    bus.y    = 256'd1;
    bus.z    = 256'd2;
    bus.p    = 256'd31;
    bus.flag = 1'b1;
    @(negedge clk);
    bus.flag = 1'b0;
    wait_done("t4", 300);
`else
    wait_done("t4", 0);
`endif
    check_result("t4", pick(256'd23, 256'd9), pick(256'd19, 256'd5), pick(256'd3, 256'd1));
    // Request in the DONE cycle is dropped.
    bus.x    = 256'd1;
    bus.y    = 256'd1;
    bus.z    = 256'd2;
    bus.p    = 256'd29;
    bus.flag = 1'b1;
    @(negedge clk);
    bus.flag = 1'b0;
    check_value("t4_done_flag_busy", {255'd0, bus.busy}, 256'd0);
    check_value("t4_done_flag_done", {255'd0, bus.conv_done}, 256'd0);
    start_conv(256'd1, 256'd1, 256'd2, 256'd29);
    wait_done("t4b", 0);
    check_result("t4b", pick(256'd4, 256'd1), pick(256'd8, 256'd1), pick(256'd2, 256'd1));
    check_pulse_end("t4b");

    // Reset in the middle of a conversion discards it.
    start_conv(256'd9, 256'd5, 256'd3, 256'd29);
    repeat (499) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    check_result("t5_rst", 256'd0, 256'd0, 256'd0);
    check_value("t5_rst_busy", {255'd0, bus.busy}, 256'd0);
    check_value("t5_rst_done", {255'd0, bus.conv_done}, 256'd0);
    nrst   = 1'b1;
    pulses = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (bus.conv_done === 1'b1) pulses++;
    end
    check_value("t5_no_done", WIDTH'(pulses), 256'd0);
    start_conv(256'd9, 256'd5, 256'd3, 256'd29);
    wait_done("t5", 0);
    check_result("t5", pick(256'd23, 256'd9), pick(256'd19, 256'd5), pick(256'd3, 256'd1));
    check_pulse_end("t5");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
